// File: rtl/fetch_redirect_unit_if.sv
// Handshake bundle between the fetch redirect unit and its neighbours:
// squash notification, instruction-memory request/response, decode output.
// Optional squash statistics are present when FETCH_SQUASH_STATS_EN is defined.
interface fetch_redirect_unit_if #(
    parameter int p_seq_num_bits = 5
);
    logic                      squash_val;
    logic [31:0]               squash_target;
    logic [p_seq_num_bits-1:0] squash_seq_num;

    logic                      mem_req_val;
    logic                      mem_req_rdy;
    logic [31:0]               mem_req_addr;

    logic                      mem_resp_val;
    logic                      mem_resp_rdy;
    logic [31:0]               mem_resp_data;

    logic                      D_val;
    logic                      D_rdy;
    logic [31:0]               D_inst;
    logic [31:0]               D_pc;

`ifdef FETCH_SQUASH_STATS_EN
    logic [31:0]               squash_count;
    logic [p_seq_num_bits-1:0] last_squash_seq_num;
    logic [31:0]               dropped_count;
`endif

    // Fetch unit side.
    modport slave (
        input  squash_val, squash_target, squash_seq_num,
        output mem_req_val, mem_req_addr,
        input  mem_req_rdy,
        input  mem_resp_val, mem_resp_data,
        output mem_resp_rdy,
        output D_val, D_inst, D_pc,
        input  D_rdy
`ifdef FETCH_SQUASH_STATS_EN
        , output squash_count, last_squash_seq_num, dropped_count
`endif
    );

    // Environment side (execute, memory, decode).
    modport master (
        output squash_val, squash_target, squash_seq_num,
        input  mem_req_val, mem_req_addr,
        output mem_req_rdy,
        output mem_resp_val, mem_resp_data,
        input  mem_resp_rdy,
        input  D_val, D_inst, D_pc,
        output D_rdy
`ifdef FETCH_SQUASH_STATS_EN
        , input squash_count, last_squash_seq_num, dropped_count
`endif
    );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Fetch redirect unit: owns the fetch PC, issues in-order instruction fetches,
// tracks the PC of each outstanding fetch in a small FIFO, and on a squash
// redirects the PC and discards every response belonging to older fetches.
// Optional macro FETCH_SQUASH_STATS_EN adds squash/drop statistics outputs.
module fetch_redirect_unit #(
    parameter int          p_seq_num_bits  = 5,
    parameter int          p_max_in_flight = 4,
    parameter logic [31:0] p_reset_pc      = 32'h0000_0200
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_redirect_unit_if.slave bus
);
    localparam int            PW      = $clog2(p_max_in_flight);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(p_max_in_flight);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   fifo_q [p_max_in_flight];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          req_fire;
    logic          resp_fire;
    logic          dropping;

    // A response is thrown away while stale fetches remain or a squash is live.
    assign dropping = (drop_q != '0) || bus.squash_val;

    // Full is judged on the pre-pop count, so a same-cycle pop never frees a slot.
    assign bus.mem_req_val   = !rst && !bus.squash_val && (cnt_q < MAX_CNT);
    assign bus.mem_req_addr  = pc_q;
    assign bus.mem_resp_rdy  = !rst && (dropping || bus.D_rdy);
    assign bus.D_val         = !rst && bus.mem_resp_val && !dropping;
    assign bus.D_inst        = bus.mem_resp_data;
    assign bus.D_pc          = fifo_q[head_q];

    assign req_fire  = bus.mem_req_val && bus.mem_req_rdy;
    assign resp_fire = bus.mem_resp_val && bus.mem_resp_rdy;

    // Next-state for PC, FIFO pointers, occupancy and pending-drop count.
    always_comb begin
        pc_d   = pc_q;
        head_d = head_q;
        tail_d = tail_q;
        drop_d = drop_q;
        if (req_fire) begin
            pc_d   = pc_q + 32'd4;
            tail_d = tail_q + 1'b1;
        end
        if (resp_fire) begin
            head_d = head_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(req_fire) - CW'(resp_fire);
        if (bus.squash_val) begin
            // Everything still outstanding after this cycle is older than the squash.
            pc_d   = {bus.squash_target[31:2], 2'b00};
            drop_d = cnt_q - CW'(resp_fire);
        end else if (resp_fire && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
    end

    // Control state, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= p_reset_pc;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    // PC storage for outstanding fetches; contents only matter while occupied.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            fifo_q[tail_q] <= pc_q;
        end
    end

`ifdef FETCH_SQUASH_STATS_EN
    logic [31:0]               squash_count_q;
    logic [p_seq_num_bits-1:0] last_seq_q;
    logic [31:0]               dropped_count_q;
    logic                      unused_bits;

    assign unused_bits             = ^bus.squash_target[1:0];
    assign bus.squash_count        = squash_count_q;
    assign bus.last_squash_seq_num = last_seq_q;
    assign bus.dropped_count       = dropped_count_q;

    // Squash and discarded-response statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            squash_count_q  <= '0;
            last_seq_q      <= '0;
            dropped_count_q <= '0;
        end else begin
            if (bus.squash_val) begin
                squash_count_q <= squash_count_q + 32'd1;
                last_seq_q     <= bus.squash_seq_num;
            end
            if (resp_fire && dropping) begin
                dropped_count_q <= dropped_count_q + 32'd1;
            end
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{bus.squash_target[1:0], bus.squash_seq_num};
`endif

`ifndef SYNTHESIS
    // A response with nothing outstanding means the memory broke ordering.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.mem_resp_val && (cnt_q == '0)))
                else $error("fetch_redirect_unit: response with no request outstanding");
        end
    end
`endif
endmodule
